pwm_duty_sequencer: RTL and testbench

Controller that sequences a single-channel PWM datapath from ADC samples.
- Accepts 4-bit samples via a valid/ready handshake into a one-entry pending buffer.
- Commits samples only at PWM period boundaries, so the output never glitches.
- Slews the applied duty toward the target by at most STEP per period (soft start / slew limit).
- Sits between the ADC front-end and the PWM output pin and owns the period counter.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_period_counter.sv | 20 ++
 rtl/pwm_duty_sequencer.sv | 102 ++++++++++
 tb/tb_pwm_duty_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM duty sequencer and its period counter.
// Pure declarations: no logic, no latency, no flow control of its own.
package pwm_pkg;

  localparam int          CNT_W_DEF = 4;
  localparam int unsigned STEP_DEF  = 2;

  typedef enum logic [1:0] {OFF, RUN, SLEW} state_t;

  // Move cur toward tgt by at most step; computed wide so it can neither wrap nor overshoot.
  function automatic int unsigned step_toward(input int unsigned cur,
                                              input int unsigned tgt,
                                              input int unsigned step);
    if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
    return (cur - tgt <= step) ? tgt : cur - step;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Wrapping W-bit period counter with synchronous clear (priority) and increment enable.
// cnt is registered; wrap is combinational on cnt==2^W-1; no backpressure.
module pwm_period_counter #(
  parameter int W = 4
) (
  input  logic         cLK,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  always_ff @(posedge cLK) begin
    if (clr)      cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  end

  assign wrap = &cnt;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Commits ADC duty requests at period boundaries and slews the applied duty by <= STEP per period.
// duty/PWM/busy registered; one-entry pending buffer, adc_ready low while it holds a value.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int          CNT_W = CNT_W_DEF,
  parameter int unsigned STEP  = STEP_DEF
) (
  input  logic             cLK,
  input  logic             Reset,
  input  logic             En,
  input  logic             adc_valid,
  input  logic [CNT_W-1:0] ADC,
  output logic             adc_ready,
  output logic [CNT_W-1:0] duty,
  output logic             period_start,
  output logic             busy,
  output logic             PWM
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               wrap;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   pend_val_q, pend_val_d;
  logic               pend_full_q, pend_full_d;
  logic               busy_q, busy_d;
  logic               pwm_q, pwm_d;
  logic               running;
  logic               xfer;
  logic               boundary;
  logic [CNT_W-1:0]   commit_t;

  assign running  = (state_q != OFF);
  assign xfer     = adc_valid && adc_ready;
  assign boundary = running && En && wrap;
  assign commit_t = pend_full_q ? pend_val_q : target_q;

  // Counter stays at 0 on the OFF->running transition so the first running cycle is cnt==0.
  pwm_period_counter #(.W(CNT_W)) u_cnt (
    .cLK  (cLK),
    .clr  (Reset || !En),
    .inc  (running),
    .cnt  (cnt),
    .wrap (wrap)
  );

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    target_d    = target_q;
    pend_val_d  = pend_val_q;
    pend_full_d = pend_full_q;
    if (!En) begin
      state_d     = OFF;
      duty_d      = '0;
      pend_full_d = 1'b0;
    end else begin
      if (boundary) begin
        target_d    = commit_t;
        duty_d      = CNT_W'(step_toward(32'(duty_q), 32'(commit_t), STEP));
        pend_full_d = 1'b0;
      end
      // A transfer on the boundary cycle lands in pending for the next boundary.
      if (xfer) begin
        pend_full_d = 1'b1;
        pend_val_d  = ADC;
      end
      state_d = (duty_d == target_d) ? RUN : SLEW;
    end
    busy_d = (duty_d != target_d);
    pwm_d  = En && running && (cnt < duty_q);
  end

  always_ff @(posedge cLK) begin
    if (Reset) begin
      state_q     <= OFF;
      duty_q      <= '0;
      target_q    <= '0;
      pend_val_q  <= '0;
      pend_full_q <= 1'b0;
      busy_q      <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      pend_val_q  <= pend_val_d;
      pend_full_q <= pend_full_d;
      busy_q      <= busy_d;
      pwm_q       <= pwm_d;
    end
  end

  assign adc_ready    = running && !pend_full_q;
  assign period_start = running && (cnt == '0);
  assign duty         = duty_q;
  assign busy         = busy_q;
  assign PWM          = pwm_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Scoreboard bench: a per-period reference model predicts every cycle's outputs; a negedge monitor compares.
module tb_pwm_duty_sequencer;

  localparam int STEP   = 2;
  localparam int PERIOD = 16;

  logic       cLK = 1'b0;
  logic       Reset, En, adc_valid;
  logic [3:0] ADC;
  logic       adc_ready, period_start, busy, PWM;
  logic [3:0] duty;

  pwm_duty_sequencer #(.CNT_W(4), .STEP(2)) dut (
    .cLK          (cLK),
    .Reset        (Reset),
    .En           (En),
    .adc_valid    (adc_valid),
    .ADC          (ADC),
    .adc_ready    (adc_ready),
    .duty         (duty),
    .period_start (period_start),
    .busy         (busy),
    .PWM          (PWM)
  );

  always #5 cLK = ~cLK;

  typedef struct {
    bit rdy;
    bit ps;
    bit pwm;
    int duty;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed  = 0;

  // Reference model: position within the period, applied duty, committed target, pending queue.
  bit m_on   = 0;
  int m_pos  = 0;
  int m_duty = 0;
  int m_tgt  = 0;
  int m_pend[$];
  bit m_pwm  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input bit rst, input bit en, input bit vld, input int adc);
    bit rdy;
    int t, delta;
    Reset = rst; En = en; adc_valid = vld; ADC = 4'(adc);
    rdy = m_on && (m_pend.size() == 0);
    if (armed) exp_q.push_back('{rdy, m_on && m_pos == 0, m_pwm, m_duty, m_duty != m_tgt});
    if (rst) begin
      m_on = 0; m_pos = 0; m_duty = 0; m_tgt = 0; m_pend.delete(); m_pwm = 0;
    end else if (!en) begin
      m_on = 0; m_pos = 0; m_duty = 0; m_pend.delete(); m_pwm = 0;
    end else if (!m_on) begin
      m_on = 1; m_pos = 0; m_pwm = 0;
    end else begin
      m_pwm = (m_pos < m_duty);
      if (m_pos == PERIOD - 1) begin
        t = (m_pend.size() != 0) ? m_pend.pop_front() : m_tgt;
        m_tgt = t;
        delta = t - m_duty;
        if (delta > STEP)  delta = STEP;
        if (delta < -STEP) delta = -STEP;
        m_duty = m_duty + delta;
      end
      if (rdy && vld) m_pend.push_back(adc);
      m_pos = (m_pos + 1) % PERIOD;
    end
    @(posedge cLK);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick(0, 1, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge cLK);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("adc_ready",    int'(adc_ready),    int'(e.rdy));
        chk("period_start", int'(period_start), int'(e.ps));
        chk("pwm",          int'(PWM),          int'(e.pwm));
        chk("duty",         int'(duty),         e.duty);
        chk("busy",         int'(busy),         int'(e.busy));
      end
    end
  end

  initial begin : stim
    int seq_up[4]   = '{2, 4, 6, 7};
    int seq_dn[8]   = '{13, 11, 9, 7, 5, 3, 1, 0};
    int seq_re[5]   = '{2, 4, 6, 8, 10};
    int highs;
    bit en_r;
    Reset = 1; En = 0; adc_valid = 0; ADC = 0;
    repeat (2) @(posedge cLK);
    #1;
    // Reset held three cycles with En and adc_valid asserted.
    tick(1, 1, 1, 15);
    armed = 1;
    tick(1, 1, 1, 15);
    tick(1, 1, 1, 15);
    chk("rst_duty", int'(duty), 0);
    chk("rst_ready", int'(adc_ready), 0);
    chk("rst_pwm", int'(PWM), 0);
    chk("rst_pstart", int'(period_start), 0);
    tick(0, 1, 0, 0);
    chk("first_pstart", int'(period_start), 1);

    // Soft start toward 7.
    tick(0, 1, 1, 7);
    for (int i = 0; i < 4; i++) begin
      run(i == 0 ? 15 : 16);
      chk("ramp_up_duty", int'(duty), seq_up[i]);
    end
    chk("ramp_up_busy", int'(busy), 0);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (PWM) highs++;
      tick(0, 1, 0, 0);
    end
    chk("pwm_highs_7", highs, 7);

    // Up to 15, then down to 0.
    tick(0, 1, 1, 15);
    run(15 + 48);
    chk("duty_15", int'(duty), 15);
    tick(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin
      run(i == 0 ? 15 : 16);
      chk("ramp_dn_duty", int'(duty), seq_dn[i]);
    end
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (PWM) highs++;
      tick(0, 1, 0, 0);
    end
    chk("pwm_highs_0", highs, 0);

    // Transfer at cnt=3, second offer ignored while pending is full.
    run(3);
    tick(0, 1, 1, 5);
    for (int i = 0; i < 12; i++) begin
      chk("ready_low_window", int'(adc_ready), 0);
      tick(0, 1, 1, 9);
    end
    chk("ready_back", int'(adc_ready), 1);
    run(32);
    chk("target5_duty", int'(duty), 5);
    chk("target5_busy", int'(busy), 0);

    // Transfer exactly on the boundary cycle commits one period later.
    tick(0, 1, 1, 0);
    run(15 + 32);
    chk("back_to_0", int'(duty), 0);
    run(15);
    tick(0, 1, 1, 4);
    chk("bnd_xfer_duty", int'(duty), 0);
    chk("bnd_xfer_ready", int'(adc_ready), 0);
    run(16);
    chk("bnd_xfer_next", int'(duty), 2);

    // En drop mid-period at duty 10, then soft restart.
    tick(0, 1, 1, 10);
    run(15 + 48);
    chk("duty_10", int'(duty), 10);
    run(6);
    tick(0, 0, 0, 0);
    chk("off_pwm", int'(PWM), 0);
    chk("off_duty", int'(duty), 0);
    chk("off_ready", int'(adc_ready), 0);
    tick(0, 0, 1, 3);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      run(16);
      chk("restart_duty", int'(duty), seq_re[i]);
    end

    // Random traffic with enable drops and occasional resets.
    en_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if (en_r) en_r = ($urandom_range(149) != 0);
      else      en_r = ($urandom_range(3) == 0);
      tick($urandom_range(399) == 0, en_r, $urandom_range(2) == 0, int'($urandom_range(15)));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
